// File: rtl/jtcps15_snd_pkg.sv
// ============================================================================
// jtcps15_snd_pkg : shared types/constants for the CPS1.5 sound ROM arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package jtcps15_snd_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    Z80_BUSY = 2'd1,
    QS_BUSY  = 2'd2
  } state_e;

  localparam int          STARVE_W        = 3;
  localparam logic [22:0] Z80_OFFSET_DEF  = 23'h000000;
  localparam logic [22:0] QSND_OFFSET_DEF = 23'h080000;

endpackage

`default_nettype wire

// File: rtl/jtcps15_snd_cache.sv
// ============================================================================
// jtcps15_snd_cache : one-entry read cache (tag, byte, valid)
// Rev 1.0
// ============================================================================
`default_nettype none

module jtcps15_snd_cache
  import jtcps15_snd_pkg::*;
#(
  parameter int AW = 19
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          fill,
  input  logic [AW-1:0] fill_addr,
  input  logic [7:0]    fill_data,
  output logic [7:0]    data,
  output logic          ok
);

  logic          valid_q;
  logic [AW-1:0] tag_q;
  logic [7:0]    data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= 8'h00;
    end else begin
      if (fill) begin
        tag_q  <= fill_addr;
        data_q <= fill_data;
      end
      // a fill landing together with flush must not leave a valid entry
      valid_q <= (valid_q | fill) & ~flush;
    end
  end

  assign data = data_q;
  assign ok   = cs & valid_q & (addr == tag_q);

endmodule

`default_nettype wire

// File: rtl/jtcps15_sndrom_arb.sv
// ============================================================================
// jtcps15_sndrom_arb : Z80 / QSound ROM arbiter onto one SDRAM read port
// Rev 1.0
// ============================================================================
`default_nettype none

module jtcps15_sndrom_arb
  import jtcps15_snd_pkg::*;
#(
  parameter logic [22:0] Z80_OFFSET  = Z80_OFFSET_DEF,
  parameter logic [22:0] QSND_OFFSET = QSND_OFFSET_DEF,
  parameter int          STARVE      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        z80_cs,
  input  logic [18:0] z80_addr,
  output logic [7:0]  z80_data,
  output logic        z80_ok,
  input  logic        qsnd_cs,
  input  logic [22:0] qsnd_addr,
  output logic [7:0]  qsnd_data,
  output logic        qsnd_ok,
  output logic        sdram_cs,
  output logic [22:0] sdram_addr,
  input  logic [7:0]  sdram_data,
  input  logic        sdram_ok
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE);

  state_e              state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [22:0]         lat_q, lat_d;
  logic [22:0]         sdram_addr_q, sdram_addr_d;
  logic                sdram_cs_q, sdram_cs_d;

  logic z80_miss, qs_miss;
  logic z80_fill, qs_fill;
  logic grant_z, grant_q;

  assign z80_miss = z80_cs & ~z80_ok;
  assign qs_miss  = qsnd_cs & ~qsnd_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_q     <= '0;
      lat_q        <= '0;
      sdram_addr_q <= '0;
      sdram_cs_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      lat_q        <= lat_d;
      sdram_addr_q <= sdram_addr_d;
      sdram_cs_q   <= sdram_cs_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    sdram_addr_d = sdram_addr_q;
    sdram_cs_d   = sdram_cs_q;
    z80_fill     = 1'b0;
    qs_fill      = 1'b0;
    grant_z      = 1'b0;
    grant_q      = 1'b0;
    case (state_q)
      IDLE: begin
        // Z80 wins ties until QSound has waited STARVE Z80 grants
        if (z80_miss && (!qs_miss || starve_q != STARVE_LIM)) begin
          grant_z      = 1'b1;
          state_d      = Z80_BUSY;
          lat_d        = {4'd0, z80_addr};
          sdram_addr_d = {4'd0, z80_addr} + Z80_OFFSET;
          sdram_cs_d   = 1'b1;
        end else if (qs_miss) begin
          grant_q      = 1'b1;
          state_d      = QS_BUSY;
          lat_d        = qsnd_addr;
          sdram_addr_d = qsnd_addr + QSND_OFFSET;
          sdram_cs_d   = 1'b1;
        end
      end
      Z80_BUSY: begin
        if (sdram_ok) begin
          z80_fill   = 1'b1;
          state_d    = IDLE;
          sdram_cs_d = 1'b0;
        end
      end
      QS_BUSY: begin
        if (sdram_ok) begin
          qs_fill    = 1'b1;
          state_d    = IDLE;
          sdram_cs_d = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        sdram_cs_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (!qs_miss || grant_q) begin
      starve_d = '0;
    end else if (grant_z && starve_q != '1) begin
      starve_d = starve_q + 1'b1;
    end
  end

  assign sdram_cs   = sdram_cs_q;
  assign sdram_addr = sdram_addr_q;

  jtcps15_snd_cache #(.AW(19)) u_z80_cache (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .cs        (z80_cs),
    .addr      (z80_addr),
    .fill      (z80_fill),
    .fill_addr (lat_q[18:0]),
    .fill_data (sdram_data),
    .data      (z80_data),
    .ok        (z80_ok)
  );

  jtcps15_snd_cache #(.AW(23)) u_qs_cache (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .cs        (qsnd_cs),
    .addr      (qsnd_addr),
    .fill      (qs_fill),
    .fill_addr (lat_q),
    .fill_data (sdram_data),
    .data      (qsnd_data),
    .ok        (qsnd_ok)
  );

endmodule

`default_nettype wire

// File: tb/tb_jtcps15_sndrom_arb.sv
// ============================================================================
// tb_jtcps15_sndrom_arb : directed + randomized bench for the sound ROM arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_jtcps15_sndrom_arb;

  localparam int LIVE_BOUND = 200;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        z80_cs, qsnd_cs;
  logic [18:0] z80_addr;
  logic [22:0] qsnd_addr;
  logic [7:0]  z80_data, qsnd_data;
  logic        z80_ok, qsnd_ok;
  logic        sdram_cs;
  logic [22:0] sdram_addr;
  logic [7:0]  sdram_data;
  logic        sdram_ok;

  logic        man_ok, rsp_ok, resp_en;
  logic [7:0]  man_data, rsp_data;

  int checks   = 0;
  int failures = 0;

  assign sdram_ok   = resp_en ? rsp_ok   : man_ok;
  assign sdram_data = resp_en ? rsp_data : man_data;

  always #5 clk = ~clk;

  jtcps15_sndrom_arb dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .z80_cs     (z80_cs),
    .z80_addr   (z80_addr),
    .z80_data   (z80_data),
    .z80_ok     (z80_ok),
    .qsnd_cs    (qsnd_cs),
    .qsnd_addr  (qsnd_addr),
    .qsnd_data  (qsnd_data),
    .qsnd_ok    (qsnd_ok),
    .sdram_cs   (sdram_cs),
    .sdram_addr (sdram_addr),
    .sdram_data (sdram_data),
    .sdram_ok   (sdram_ok)
  );

  // Memory contents seen through the SDRAM port, keyed by byte address
  function automatic logic [7:0] memfn(input logic [22:0] a);
    return a[7:0] ^ {a[22:19], a[18:15]} ^ 8'h3C;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cs(output logic got);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sdram_cs) begin
        got = 1'b1;
        return;
      end
      cyc();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; z80_cs = 1'b0; qsnd_cs = 1'b0;
    z80_addr = '0; qsnd_addr = '0; man_ok = 1'b0; man_data = 8'h00;
    cyc(); cyc(); cyc();
    rst = 1'b0;
  endtask

  // SDRAM responder for the randomized phase: random 1..4 cycle latency
  initial begin
    int cnt;
    cnt = -1;
    rsp_ok = 1'b0;
    rsp_data = 8'h00;
    forever begin
      cyc();
      rsp_ok = 1'b0;
      if (resp_en && sdram_cs) begin
        if (cnt < 0) cnt = int'($urandom_range(0, 3));
        if (cnt == 0) begin
          rsp_ok   = 1'b1;
          rsp_data = memfn(sdram_addr);
          cnt      = -1;
        end else begin
          cnt--;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        got;
    logic [22:0] exp_addr [4];
    logic        prev_cs;
    logic [22:0] prev_addr;
    int          z_wait, q_wait;

    resp_en = 1'b0;
    do_reset();

    // reset state
    z80_cs = 1'b1; qsnd_cs = 1'b1; #1;
    chk("rst_sdram_cs", sdram_cs, 0);
    chk("rst_sdram_addr", sdram_addr, 0);
    chk("rst_z80_ok", z80_ok, 0);
    chk("rst_qsnd_ok", qsnd_ok, 0);
    chk("rst_z80_data", z80_data, 0);
    chk("rst_qsnd_data", qsnd_data, 0);
    z80_cs = 1'b0; qsnd_cs = 1'b0;

    // basic Z80 miss, 4-cycle SDRAM latency, then repeat hit
    cyc();
    z80_cs = 1'b1; z80_addr = 19'h01234; #1;
    chk("t1_miss_ok", z80_ok, 0);
    chk("t1_cs_before", sdram_cs, 0);
    cyc();
    chk("t1_cs", sdram_cs, 1);
    chk("t1_addr", sdram_addr, 23'h001234);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t1_cs_hold", sdram_cs, 1);
    end
    cyc();
    man_ok = 1'b1; man_data = 8'hA5; #1;
    chk("t1_ok_early", z80_ok, 0);
    cyc();
    man_ok = 1'b0; man_data = 8'h00; #1;
    chk("t1_hit_ok", z80_ok, 1);
    chk("t1_hit_data", z80_data, 8'hA5);
    chk("t1_cs_fall", sdram_cs, 0);
    cyc();
    chk("t1_repeat_no_cs", sdram_cs, 0);
    chk("t1_repeat_ok", z80_ok, 1);
    z80_cs = 1'b0;

    // address change while busy: fill keeps the old address
    cyc();
    z80_cs = 1'b1; z80_addr = 19'h00100;
    cyc();
    chk("t2_addr", sdram_addr, 23'h000100);
    z80_addr = 19'h00101;
    cyc();
    man_ok = 1'b1; man_data = 8'h11;
    cyc();
    man_ok = 1'b0; z80_addr = 19'h00100; #1;
    chk("t2_old_tag_ok", z80_ok, 1);
    chk("t2_old_tag_data", z80_data, 8'h11);
    chk("t2_cs_idle", sdram_cs, 0);
    cyc();
    z80_addr = 19'h00101; #1;
    chk("t2_new_miss", z80_ok, 0);
    cyc();
    chk("t2_second_cs", sdram_cs, 1);
    chk("t2_second_addr", sdram_addr, 23'h000101);
    man_ok = 1'b1; man_data = 8'h22;
    cyc();
    man_ok = 1'b0; #1;
    chk("t2_second_data", z80_data, 8'h22);
    z80_cs = 1'b0;

    // flush in the fill cycle discards the fill
    cyc();
    qsnd_cs = 1'b1; qsnd_addr = 23'h000200;
    cyc();
    chk("t3_addr", sdram_addr, 23'h080200);
    cyc();
    man_ok = 1'b1; man_data = 8'h33; flush = 1'b1;
    cyc();
    man_ok = 1'b0; flush = 1'b0; z80_cs = 1'b1; #1;
    chk("t3_qs_discard", qsnd_ok, 0);
    chk("t3_z80_flushed", z80_ok, 0);
    chk("t3_cs_idle", sdram_cs, 0);
    z80_cs = 1'b0;
    cyc();
    chk("t3_reissue_cs", sdram_cs, 1);
    chk("t3_reissue_addr", sdram_addr, 23'h080200);
    man_ok = 1'b1; man_data = 8'h44;
    cyc();
    man_ok = 1'b0; #1;
    chk("t3_fill_ok", qsnd_ok, 1);
    chk("t3_fill_data", qsnd_data, 8'h44);
    qsnd_cs = 1'b0;

    // reset while QS_BUSY, late sdram_ok is ignored
    cyc();
    qsnd_cs = 1'b1; qsnd_addr = 23'h000300;
    cyc();
    chk("t4_busy_addr", sdram_addr, 23'h080300);
    rst = 1'b1; qsnd_cs = 1'b0;
    cyc();
    rst = 1'b0; #1;
    chk("t4_cs", sdram_cs, 0);
    chk("t4_addr", sdram_addr, 0);
    chk("t4_qdata", qsnd_data, 0);
    chk("t4_zdata", z80_data, 0);
    cyc();
    man_ok = 1'b1; man_data = 8'h55;
    cyc();
    man_ok = 1'b0; qsnd_cs = 1'b1; #1;
    chk("t4_no_fill_ok", qsnd_ok, 0);
    chk("t4_no_fill_data", qsnd_data, 0);
    chk("t4_idle_cs", sdram_cs, 0);
    cyc();
    chk("t4_new_cs", sdram_cs, 1);
    chk("t4_new_addr", sdram_addr, 23'h080300);
    man_ok = 1'b1; man_data = 8'h66;
    cyc();
    man_ok = 1'b0; #1;
    chk("t4_fill_data", qsnd_data, 8'h66);

    // QSound hits while a Z80 transaction is in flight
    z80_cs = 1'b1; z80_addr = 19'h00777;
    cyc();
    chk("t5_z_addr", sdram_addr, 23'h000777);
    cyc();
    chk("t5_qs_hit", qsnd_ok, 1);
    chk("t5_qs_hit_data", qsnd_data, 8'h66);
    qsnd_addr = 23'h000301; #1;
    chk("t5_qs_miss", qsnd_ok, 0);
    chk("t5_addr_stable", sdram_addr, 23'h000777);
    cyc();
    man_ok = 1'b1; man_data = 8'h77;
    cyc();
    man_ok = 1'b0; #1;
    chk("t5_z_data", z80_data, 8'h77);
    cyc();
    chk("t5_qs_grant_addr", sdram_addr, 23'h080301);
    man_ok = 1'b1; man_data = 8'h88;
    cyc();
    man_ok = 1'b0; #1;
    chk("t5_qs_data", qsnd_data, 8'h88);
    z80_cs = 1'b0; qsnd_cs = 1'b0;

    // starvation limit: three Z80 grants then QSound
    do_reset();
    exp_addr[0] = 23'h00000A; exp_addr[1] = 23'h00000B;
    exp_addr[2] = 23'h00000C; exp_addr[3] = 23'h080010;
    z80_cs = 1'b1; z80_addr = 19'h0000A;
    qsnd_cs = 1'b1; qsnd_addr = 23'h000010;
    for (int k = 0; k < 4; k++) begin
      wait_cs(got);
      chk("t6_grant_seen", got, 1);
      chk("t6_grant_addr", sdram_addr, exp_addr[k]);
      man_ok = 1'b1; man_data = 8'(k);
      if (k < 3) z80_addr = z80_addr + 19'd1;
      cyc();
      man_ok = 1'b0;
    end
    #1;
    chk("t6_qs_ok", qsnd_ok, 1);
    cyc();
    chk("t6_z_after_addr", sdram_addr, 23'h00000D);
    man_ok = 1'b1; man_data = 8'hEE;
    cyc();
    man_ok = 1'b0; z80_cs = 1'b0; qsnd_cs = 1'b0;

    // randomized traffic against the memory model
    do_reset();
    resp_en = 1'b1;
    prev_cs = 1'b0; prev_addr = '0; z_wait = 0; q_wait = 0;
    for (int n = 0; n < 3000; n++) begin
      cyc();
      if (prev_cs && sdram_cs) chk("r_addr_stable", sdram_addr, prev_addr);
      prev_cs = sdram_cs; prev_addr = sdram_addr;
      if (z80_cs) begin
        if (z80_ok) begin
          chk("r_z80_data", z80_data, memfn({4'd0, z80_addr}));
          chk("r_z80_live", z_wait <= LIVE_BOUND, 1);
          z80_cs = ($urandom_range(0, 3) != 0);
          z80_addr = 19'($urandom_range(0, 7));
          z_wait = 0;
        end else begin
          z_wait++;
        end
      end else if ($urandom_range(0, 1) == 1) begin
        z80_cs = 1'b1; z80_addr = 19'($urandom_range(0, 7));
      end
      if (qsnd_cs) begin
        if (qsnd_ok) begin
          chk("r_qs_data", qsnd_data, memfn(qsnd_addr + 23'h080000));
          chk("r_qs_live", q_wait <= LIVE_BOUND, 1);
          qsnd_cs = ($urandom_range(0, 3) != 0);
          qsnd_addr = 23'($urandom_range(0, 7));
          q_wait = 0;
        end else begin
          q_wait++;
        end
      end else if ($urandom_range(0, 1) == 1) begin
        qsnd_cs = 1'b1; qsnd_addr = 23'($urandom_range(0, 7));
      end
      flush = ($urandom_range(0, 31) == 0);
    end
    chk("r_z80_final_wait", z_wait <= LIVE_BOUND, 1);
    chk("r_qs_final_wait", q_wait <= LIVE_BOUND, 1);
    z80_cs = 1'b0; qsnd_cs = 1'b0; flush = 1'b0;
    for (int i = 0; i < 20 && sdram_cs; i++) cyc();
    chk("r_drain", sdram_cs, 0);
    resp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/jtcps15_sndrom_arb.md
JTCPS15_SNDROM_ARB -- requirements
Module: jtcps15_sndrom_arb

Interface
REQ-001 Parameter Z80_OFFSET, default 23'h000000, SDRAM byte offset added to Z80 ROM addresses.
REQ-002 Parameter QSND_OFFSET, default 23'h080000, SDRAM byte offset added to QSound sample addresses.
REQ-003 Parameter STARVE, default 3, maximum number of consecutive Z80 grants while a QSound miss waits.
REQ-004 Port list:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- flush  in  1  invalidates both caches (ROM download)
- z80_cs  in  1  Z80 ROM request
- z80_addr  in  19  Z80 ROM byte address
- z80_data  out  8  Z80 read data
- z80_ok  out  1  z80_data valid for z80_addr
- qsnd_cs  in  1  QSound sample request
- qsnd_addr  in  23  sample byte address
- qsnd_data  out  8  sample read data
- qsnd_ok  out  1  qsnd_data valid for qsnd_addr
- sdram_cs  out  1  downstream request, held until acknowledged
- sdram_addr  out  23  downstream byte address
- sdram_data  in  8  downstream read data
- sdram_ok  in  1  downstream data valid

Function
REQ-005 Each requester SHALL own a one-entry cache: tag (its own address width), data byte, valid bit.
REQ-006 X_ok SHALL equal X_cs & valid_X & (X_addr == tag_X), combinational from registers; X_data SHALL always drive the cached byte.
REQ-007 A miss SHALL be X_cs & ~X_ok.
REQ-008 The FSM SHALL have states IDLE, Z80_BUSY and QS_BUSY.
REQ-009 In IDLE with only one miss, that requester SHALL be granted at the next clock edge.
REQ-010 In IDLE with both misses, Z80 SHALL be granted unless starve_cnt == STARVE, in which case QSound SHALL be granted.
REQ-011 starve_cnt (3 bits, saturating) SHALL:
- increment on a Z80 grant while a QSound miss is present;
- clear on a QSound grant;
- clear in any cycle with no QSound miss.
REQ-012 On grant, the requester address SHALL be latched, and the FSM SHALL drive sdram_addr = latched address zero-extended to 23 bits + offset (modulo 2^23) and sdram_cs = 1 from the following cycle.
REQ-013 sdram_cs and sdram_addr SHALL stay stable while in a BUSY state; sdram_ok SHALL be ignored in IDLE.
REQ-014 On sdram_ok in a BUSY state, the granted cache SHALL load tag = latched address, data = sdram_data, valid = 1. In the same edge the FSM SHALL return to IDLE and sdram_cs SHALL fall.
REQ-015 Latency: a miss in IDLE at cycle 0 SHALL give sdram_cs high in cycle 1. sdram_ok in cycle N SHALL give X_ok high in cycle N+1 if the address is unchanged. No new grant SHALL occur before cycle N+1.
REQ-016 If the granted requester changes address or drops cs while BUSY, the transaction SHALL complete and fill its cache with the old address; a new miss is then handled normally.
REQ-017 The non-granted requester SHALL still see hits from its own cache while the other is BUSY.
REQ-018 flush SHALL clear both valid bits in the same cycle.
- A fill coinciding with flush SHALL be discarded (valid stays 0).
- flush SHALL NOT abort an in-flight sdram transaction.

Reset
REQ-019 While rst is high, at every clk edge the block SHALL force state = IDLE, sdram_cs = 0, sdram_addr = 0, starve_cnt = 0, both valid bits = 0, tags = 0, and data = 8'h00.
REQ-020 Reset mid-transaction SHALL abandon it; a sdram_ok arriving after reset SHALL be ignored.

Structure
REQ-021 Package jtcps15_snd_pkg SHALL hold the state enumeration, the default offsets and the starve counter width.
REQ-022 The one-entry cache SHALL be sub-module jtcps15_snd_cache, parameterised by address width and instantiated twice.

Verification
REQ-023 Z80 miss to 19'h01234, sdram_ok 4 cycles after sdram_cs with data 8'hA5 -> sdram_addr = 23'h001234, z80_ok = 1 and z80_data = 8'hA5 one cycle after sdram_ok; a repeat read hits with no sdram_cs.
REQ-024 Simultaneous Z80 and QSound misses (QSound addr 23'h000010) with Z80 re-missing continuously -> three Z80 grants, then a QSound grant with sdram_addr = 23'h080010.
REQ-025 Z80 changes address from 19'h00100 to 19'h00101 while BUSY -> fill tagged 19'h00100; a second sdram request to 23'h000101 follows.
REQ-026 flush asserted in the sdram_ok cycle -> valid stays 0, the next identical request misses, sdram_cs is reasserted.
REQ-027 rst pulsed while QS_BUSY, with sdram_ok arriving 2 cycles later -> all outputs 0, no cache fill, FSM in IDLE.
REQ-028 QSound hits during an in-progress Z80 transaction -> qsnd_ok = 1 the same cycle, sdram_addr unchanged.
